// File: rtl/sync_fifo_param_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_param_if
// Producer/consumer handshake bundle for sync_fifo_param.
//   data_in        : write data (producer -> FIFO)
//   data_in_valid  : producer offers data_in this cycle
//   data_in_full   : FIFO cannot accept a write this cycle
//   data_out       : head-of-queue word (FIFO -> consumer)
//   data_out_valid : data_out holds the oldest unread word
//   data_out_ack   : consumer pops the presented word
// master = producer/consumer side, slave = FIFO side.
// ----------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_full;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_ack;

    modport master (
        output data_in, data_in_valid, data_out_ack,
        input  data_in_full, data_out, data_out_valid
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ack,
        output data_in_full, data_out, data_out_valid
    );
endinterface

// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with arbitrary depth, optional output register, fill
// level, almost-full/almost-empty flags, synchronous flush and sticky
// overflow/underflow flags.
// Ports:
//   clock        : clock, all state updates on rising edge
//   rst          : asynchronous active-high reset
//   flush        : synchronous clear of contents, pointers and error flags
//   bus          : write (valid/full) and read (valid/ack) handshake
//   fill_level   : words held, storage plus output register
//   almost_full  : fill_level >= ALMOST_FULL_THRESH
//   almost_empty : fill_level <= ALMOST_EMPTY_THRESH
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, ack seen while data_out_valid=0
// ----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH          = 32,
    parameter int BUFFER_SIZE         = 127,
    parameter int OUTPUT_REG          = 0,
    parameter int ALMOST_FULL_THRESH  = 120,
    parameter int ALMOST_EMPTY_THRESH = 4
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic                             flush,
    sync_fifo_param_if.slave                 bus,
    output logic [$clog2(BUFFER_SIZE+1)-1:0] fill_level,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic                             overflow,
    output logic                             underflow
);
    localparam int CNT_W     = $clog2(BUFFER_SIZE + 1);
    // The output register is one of the BUFFER_SIZE words when present.
    localparam int MEM_DEPTH = (OUTPUT_REG != 0) ? BUFFER_SIZE - 1 : BUFFER_SIZE;
    localparam int PTR_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_fill;
    logic [CNT_W-1:0]      r_mem_cnt;
    logic                  r_full;
    logic                  r_af;
    logic                  r_ae;
    logic                  r_ovf;
    logic                  r_udf;

    logic [CNT_W-1:0]      w_fill_nxt;
    logic [CNT_W-1:0]      w_mem_cnt_nxt;
    logic                  w_wr;
    logic                  w_pop;
    logic                  w_rd_en;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_mem_head;

    // Explicit wrap: MEM_DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_mem_head = r_mem[r_rd_ptr];
    assign w_wr       = bus.data_in_valid & ~r_full;
    assign w_pop      = w_out_valid & bus.data_out_ack;

    always_comb begin
        w_fill_nxt    = r_fill;
        w_mem_cnt_nxt = r_mem_cnt;
        if (w_wr && !w_pop)
            w_fill_nxt = r_fill + CNT_W'(1);
        else if (!w_wr && w_pop)
            w_fill_nxt = r_fill - CNT_W'(1);
        if (w_wr && !w_rd_en)
            w_mem_cnt_nxt = r_mem_cnt + CNT_W'(1);
        else if (!w_wr && w_rd_en)
            w_mem_cnt_nxt = r_mem_cnt - CNT_W'(1);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_mem_cnt <= '0;
            r_full    <= 1'b0;
            r_af      <= 1'b0;
            r_ae      <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_mem_cnt <= '0;
            r_full    <= 1'b0;
            r_af      <= 1'b0;
            r_ae      <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd_en)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_fill    <= w_fill_nxt;
            r_mem_cnt <= w_mem_cnt_nxt;
            // Flags come from the next fill so they line up with fill_level.
            r_full    <= (w_fill_nxt == CNT_W'(BUFFER_SIZE));
            r_af      <= (32'(w_fill_nxt) >= 32'(ALMOST_FULL_THRESH));
            r_ae      <= (32'(w_fill_nxt) <= 32'(ALMOST_EMPTY_THRESH));
            r_ovf     <= r_ovf | (bus.data_in_valid & r_full);
            r_udf     <= r_udf | (bus.data_out_ack & ~w_out_valid);
        end
    end

    // Storage array is not reset; pointers and counts define its contents.
    always_ff @(posedge clock) begin
        if (w_wr && !flush)
            r_mem[r_wr_ptr] <= bus.data_in;
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] r_dout;
            logic                  r_dvalid;

            // Refill whenever the register is empty or being popped, so a
            // non-empty store keeps the output streaming without a bubble.
            assign w_rd_en = (r_mem_cnt != '0) && (!r_dvalid || w_pop);

            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    r_dout   <= '0;
                    r_dvalid <= 1'b0;
                end else if (flush) begin
                    r_dout   <= '0;
                    r_dvalid <= 1'b0;
                end else if (w_rd_en) begin
                    r_dout   <= w_mem_head;
                    r_dvalid <= 1'b1;
                end else if (w_pop) begin
                    r_dvalid <= 1'b0;
                end
            end

            assign w_out_valid  = r_dvalid;
            assign bus.data_out = r_dout;
        end else begin : g_direct
            assign w_rd_en      = w_pop;
            assign w_out_valid  = (r_fill != '0);
            // Gated so data_out reads 0 while empty or in reset.
            assign bus.data_out = w_out_valid ? w_mem_head : '0;
        end
    endgenerate

    assign bus.data_in_full   = r_full;
    assign bus.data_out_valid = w_out_valid;
    assign fill_level         = r_fill;
    assign almost_full        = r_af;
    assign almost_empty       = r_ae;
    assign overflow           = r_ovf;
    assign underflow          = r_udf;
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's dual-clock fifo.
- Keeps the same valid/full write handshake and valid/ack read handshake.
- Adds arbitrary (non-power-of-2) depth, an optional output-register stage, a fill-level output, almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain as a rate-matching buffer.

Parameters:
- DATA_WIDTH, 32, width of data_in/data_out in bits (≥1).
- BUFFER_SIZE, 127, total storage in words, including the output register when present; any value ≥2.
- OUTPUT_REG, 0, 0 = data_out read straight from storage head; 1 = data_out driven from a dedicated output register.
- ALMOST_FULL_THRESH, 120, almost_full asserts when fill_level ≥ this value.
- ALMOST_EMPTY_THRESH, 4, almost_empty asserts when fill_level ≤ this value.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents, pointers and error flags.
- data_in  in  DATA_WIDTH  write data.
- data_in_valid  in  1  producer offers data_in this cycle.
- data_in_full  out  1  FIFO cannot accept a write this cycle.
- data_out  out  DATA_WIDTH  head-of-queue word; valid only when data_out_valid=1.
- data_out_valid  out  1  data_out holds the oldest unread word.
- data_out_ack  in  1  consumer pops the word presented this cycle.
- fill_level  out  $clog2(BUFFER_SIZE+1)  words held (storage plus output register).
- almost_full  out  1  fill_level ≥ ALMOST_FULL_THRESH.
- almost_empty  out  1  fill_level ≤ ALMOST_EMPTY_THRESH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: ack was seen while data_out_valid=0.

Behaviour:
- Reset (rst=1, asynchronous): pointers=0, fill_level=0, data_in_full=0, data_out_valid=0, data_out=0, almost_full=0, almost_empty=1, overflow=0, underflow=0. Outputs hold these values for as long as rst is high.
- Write acceptance: accept when data_in_valid & !data_in_full. data_in_full is a registered flag equal to (fill_level==BUFFER_SIZE); it is never combinational from data_out_ack.
- Write while full: the word is dropped, overflow is set, and it stays set until rst or flush.
- Read acceptance: a pop occurs when data_out_valid & data_out_ack. On the next edge the following word is presented, or data_out_valid drops if none remains.
- Ack while empty: ignored; underflow is set (sticky).
- Latency, OUTPUT_REG=0: a word written at edge N into an empty FIFO gives data_out_valid=1 after edge N (1 cycle).
- Latency, OUTPUT_REG=1: the same case gives data_out_valid=1 after edge N+1 (2 cycles). The output register refills from storage the cycle after a pop, with no bubble when storage is non-empty.
- Simultaneous write and pop: fill_level unchanged. If full, the write is still rejected, because full reflects the pre-edge state. If empty, no pop is possible, so the write proceeds normally.
- Pointer wrap: read and write pointers run 0..BUFFER_SIZE-1 and wrap to 0 explicitly. Do not use modulo-2^n arithmetic, because BUFFER_SIZE need not be a power of 2.
- fill_level arithmetic: updated as +1 (write only), -1 (pop only), or 0. It must never exceed BUFFER_SIZE or go below 0.
- almost_full and almost_empty are registered and derived from the next fill_level, so they are coherent with fill_level in the same cycle.
- Data ordering: strict FIFO order is preserved across wrap and across the output-register boundary.
- flush: at the edge, same effect as reset except it is synchronous. It overrides any same-cycle write or pop; the data_in of that cycle is discarded.
- Reset mid-operation: all contents are lost. The first word written after reset release is the first word read.

Test Plan:
- Reset, then write 1,2,4,…,2^15 (16 words) back-to-back with ack=0 → fill_level=16; almost_empty drops when fill_level reaches 5; no flags set.
- Fill BUFFER_SIZE=127 words → data_in_full=1 after the 127th write. A 128th write with valid=1 → dropped, overflow=1, fill_level stays 127. Drain all 127 → data_out sequence matches the writes exactly.
- Continuous write+ack for 300 cycles with an incrementing pattern (forces pointer wrap at 126→0) → fill_level constant, no data loss, output sequence contiguous.
- OUTPUT_REG=0 vs 1: write 32'hA5A5A5A5 into an empty FIFO → data_out_valid rises 1 vs 2 cycles later with data_out=32'hA5A5A5A5; ack pops it and valid=0 next cycle.
- Full FIFO with simultaneous write (32'hDEAD0000) and ack in the same cycle → pop occurs, write dropped, overflow=1, fill_level=126.
- With 10 words held: assert flush while data_in_valid=1 → fill_level=0, data_out_valid=0, errors cleared. Separately, ack with data_out_valid=0 → underflow=1. Asserting rst mid-burst → all outputs return to reset values asynchronously.
